pc_tx_packet: RTL

PC_TX_PACKET -- requirements
Module: pc_tx_packet

---
 rtl/pc_tx_packet_pkg.sv | 31 +++
 rtl/pc_tx_packet_crc32_d8.sv | 24 ++
 rtl/pc_tx_packet.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pc_tx_packet_pkg.sv
// Shared definitions for the Ethernet-style frame transmitter: FSM state
// encoding, fixed framing bytes, CRC-32 constants and the FCS byte picker.
package pc_tx_packet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_FCS      = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    localparam int PREAMBLE_LEN = 8;
    localparam int HEADER_LEN   = 14;
    localparam int FCS_LEN      = 4;
    localparam int CNT_W        = 11;

    // The FCS is the inverted CRC, least-significant byte on the wire first.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        logic [31:0] inv;
        inv = ~crc;
        return inv[8*idx +: 8];
    endfunction

endpackage

// File: rtl/pc_tx_packet_crc32_d8.sv
// Combinational byte-wide CRC-32 step (reflected polynomial, data LSB first).
module crc32_d8
    import pc_tx_packet_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    // Eight unrolled serial steps: feedback is the CRC LSB xor the data bit.
    always_comb begin
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/pc_tx_packet.sv
// Frame transmitter: preamble/SFD, fixed MAC header, payload drained from a
// first-word-fall-through FIFO (zero-padded on underrun), CRC-32 FCS and an
// inter-frame gap. The state names the byte being loaded into the output
// register; the very first preamble byte is loaded straight from IDLE so the
// frame starts one cycle after the request and back-to-back frames are
// separated by exactly IFG idle cycles.
module pc_tx_packet
    import pc_tx_packet_pkg::*;
#(
    parameter int          PAYLOAD_LEN = 1024,
    parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC     = 48'h000A35000001,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          IFG         = 12
)(
    input  logic       txclk,
    input  logic       txreset,
    input  logic       frame_req,
    input  logic [7:0] pix_data,
    input  logic       pix_empty,
    output logic       pix_rd_en,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       underrun
);

    localparam logic [111:0] HEADER = {DST_MAC, SRC_MAC, ETHERTYPE};

    // PREAMBLE only loads bytes 2..8; byte 1 is loaded from IDLE.
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 2);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HEADER_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((IFG > 0) ? IFG - 1 : 0);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      crc;
    logic [31:0]      crc_upd;

    logic [7:0]       load_byte_p0;
    logic             load_valid_p0;
    logic             load_pad_p0;
    logic             crc_en_p0;

    // Header byte idx of {DST, SRC, ETHERTYPE}, most significant byte first.
    function automatic logic [7:0] header_byte(input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < HEADER_LEN; i++) begin
            if (idx == 4'(i)) begin
                b = HEADER[8*(HEADER_LEN-1-i) +: 8];
            end
        end
        return b;
    endfunction

    crc32_d8 u_crc (
        .crc      (crc),
        .data     (load_byte_p0),
        .crc_next (crc_upd)
    );

    // State register.
    always_ff @(posedge txclk) begin
        if (txreset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: each state ends when its byte counter reaches its last byte.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (frame_req)       state_nxt = ST_PREAMBLE;
            ST_PREAMBLE: if (cnt == PRE_LAST) state_nxt = ST_HEADER;
            ST_HEADER:   if (cnt == HDR_LAST) state_nxt = ST_PAYLOAD;
            ST_PAYLOAD:  if (cnt == PAY_LAST) state_nxt = ST_FCS;
            ST_FCS:      if (cnt == FCS_LAST) state_nxt = (IFG > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:      if (cnt == GAP_LAST) state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: select the byte to load next, FIFO pop and CRC enable.
    always_comb begin
        load_byte_p0  = 8'h00;
        load_valid_p0 = 1'b0;
        load_pad_p0   = 1'b0;
        crc_en_p0     = 1'b0;
        pix_rd_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_req) begin
                    load_byte_p0  = PREAMBLE_BYTE;
                    load_valid_p0 = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                load_valid_p0 = 1'b1;
                load_byte_p0  = (cnt == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
            end
            ST_HEADER: begin
                load_valid_p0 = 1'b1;
                crc_en_p0     = 1'b1;
                load_byte_p0  = header_byte(cnt[3:0]);
            end
            ST_PAYLOAD: begin
                load_valid_p0 = 1'b1;
                crc_en_p0     = 1'b1;
                pix_rd_en     = ~pix_empty & ~txreset;
                load_pad_p0   = pix_empty;
                load_byte_p0  = pix_empty ? 8'h00 : pix_data;
            end
            ST_FCS: begin
                load_valid_p0 = 1'b1;
                load_byte_p0  = fcs_byte(crc, cnt[1:0]);
            end
            default: ;
        endcase
    end

    // Output register, byte counter and running CRC.
    always_ff @(posedge txclk) begin
        if (txreset) begin
            cnt      <= '0;
            crc      <= CRC_INIT;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (state_nxt != state || state == ST_IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == ST_IDLE) begin
                crc <= CRC_INIT;
            end else if (crc_en_p0) begin
                crc <= crc_upd;
            end
            tx_data  <= load_byte_p0;
            tx_valid <= load_valid_p0;
            underrun <= load_pad_p0;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
